// File: rtl/exception_ctrl_pkg.sv
// rtl/exception_ctrl_pkg.sv - exception codes, flag bit indices and FSM state for exception_ctrl
package exception_ctrl_pkg;

  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Bit positions inside exc_flags_i = {eret,ades,adel_d,brk,sys,trap,ov,ri,adel_if}
  localparam int FLAG_ADEL_IF = 0;
  localparam int FLAG_RI      = 1;
  localparam int FLAG_OV      = 2;
  localparam int FLAG_TRAP    = 3;
  localparam int FLAG_SYS     = 4;
  localparam int FLAG_BRK     = 5;
  localparam int FLAG_ADEL_D  = 6;
  localparam int FLAG_ADES    = 7;
  localparam int FLAG_ERET    = 8;
  localparam int FLAG_W       = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    COMMIT = 2'd2
  } exc_state_e;

  typedef struct packed {
    logic [31:0] etype;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] newpc;
  } exc_rec_t;

endpackage

// File: rtl/exception_ctrl_int_sync.sv
// rtl/exception_ctrl_int_sync.sv - multi-flop synchroniser for external interrupt pins
module exception_ctrl_int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] chain;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - MEM-stage exception collector: prioritise, hold across stalls, one-cycle commit to cp0
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC0_0380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [31:0]       pc_i,
  input  logic              is_in_delayslot_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [FLAG_W-1:0] exc_flags_i,
  input  logic [31:0]       status_i,
  input  logic [31:0]       cause_i,
  input  logic [31:0]       epc_i,
  input  logic [5:0]        int_i,
  output logic [5:0]        int_sync_o,
  output logic [31:0]       excepttype_o,
  output logic [31:0]       exc_pc_o,
  output logic              exc_delayslot_o,
  output logic [31:0]       bad_addr_o,
  output logic              flush_o,
  output logic [31:0]       newpc_o
);

  exception_ctrl_int_sync #(.WIDTH(6), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk (clk),
    .rst (rst),
    .d   (int_i),
    .q   (int_sync_o)
  );

  logic        int_pend;
  logic        detect;
  logic [31:0] det_type;
  logic [31:0] det_bad;
  exc_rec_t    det_rec;

  assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
  assign detect   = valid_i & (int_pend | (|exc_flags_i));

  // An interrupt outranks every flag, so its flags are simply dropped
  always_comb begin
    det_type = '0;
    det_bad  = '0;
    if (int_pend) begin
      det_type = EXC_INT;
    end else if (exc_flags_i[FLAG_ADEL_IF]) begin
      det_type = EXC_ADEL;
      det_bad  = pc_i;
    end else if (exc_flags_i[FLAG_RI]) begin
      det_type = EXC_RI;
    end else if (exc_flags_i[FLAG_OV]) begin
      det_type = EXC_OV;
    end else if (exc_flags_i[FLAG_TRAP]) begin
      det_type = EXC_TR;
    end else if (exc_flags_i[FLAG_SYS]) begin
      det_type = EXC_SYS;
    end else if (exc_flags_i[FLAG_BRK]) begin
      det_type = EXC_BP;
    end else if (exc_flags_i[FLAG_ADEL_D]) begin
      det_type = EXC_ADEL;
      det_bad  = mem_addr_i;
    end else if (exc_flags_i[FLAG_ADES]) begin
      det_type = EXC_ADES;
      det_bad  = mem_addr_i;
    end else if (exc_flags_i[FLAG_ERET]) begin
      det_type = EXC_ERET;
    end
  end

  assign det_rec = '{
    etype: det_type,
    pc:    pc_i,
    ds:    is_in_delayslot_i,
    bad:   det_bad,
    newpc: (det_type == EXC_ERET) ? epc_i : EXC_VECTOR
  };

  exc_state_e state, state_n;
  exc_rec_t   cap, cap_n;
  exc_rec_t   out_q, out_n;
  logic       flush_q, flush_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cap     <= '0;
      out_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state   <= state_n;
      cap     <= cap_n;
      out_q   <= out_n;
      flush_q <= flush_n;
    end
  end

  // Outputs are loaded only on the edge entering COMMIT, so they read zero everywhere else
  always_comb begin
    state_n = state;
    cap_n   = cap;
    out_n   = '0;
    flush_n = 1'b0;
    case (state)
      IDLE: begin
        if (detect) begin
          cap_n = det_rec;
          if (stall_i) begin
            state_n = HOLD;
          end else begin
            state_n = COMMIT;
            out_n   = det_rec;
            flush_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (!stall_i) begin
          state_n = COMMIT;
          out_n   = cap;
          flush_n = 1'b1;
        end
      end
      COMMIT: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign excepttype_o    = out_q.etype;
  assign exc_pc_o        = out_q.pc;
  assign exc_delayslot_o = out_q.ds;
  assign bad_addr_o      = out_q.bad;
  assign newpc_o         = out_q.newpc;
  assign flush_o         = flush_q;

  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - table-driven self-checking bench for exception_ctrl
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        is_in_delayslot_i;
  logic [31:0] mem_addr_i;
  logic [8:0]  exc_flags_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic [5:0]  int_i;
  logic [5:0]  int_sync_o;
  logic [31:0] excepttype_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        flush_o;
  logic [31:0] newpc_o;

  exception_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .stall_i           (stall_i),
    .valid_i           (valid_i),
    .pc_i              (pc_i),
    .is_in_delayslot_i (is_in_delayslot_i),
    .mem_addr_i        (mem_addr_i),
    .exc_flags_i       (exc_flags_i),
    .status_i          (status_i),
    .cause_i           (cause_i),
    .epc_i             (epc_i),
    .int_i             (int_i),
    .int_sync_o        (int_sync_o),
    .excepttype_o      (excepttype_o),
    .exc_pc_o          (exc_pc_o),
    .exc_delayslot_o   (exc_delayslot_o),
    .bad_addr_o        (bad_addr_o),
    .flush_o           (flush_o),
    .newpc_o           (newpc_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".type"},  excepttype_o, 32'h0);
    chk({name, ".flush"}, {31'h0, flush_o}, 32'h0);
    chk({name, ".newpc"}, newpc_o, 32'h0);
    chk({name, ".pc"},    exc_pc_o, 32'h0);
    chk({name, ".bad"},   bad_addr_o, 32'h0);
    chk({name, ".ds"},    {31'h0, exc_delayslot_o}, 32'h0);
  endtask

  task automatic clear_inputs();
    valid_i = 1'b0; exc_flags_i = '0; stall_i = 1'b0; is_in_delayslot_i = 1'b0;
    pc_i = '0; mem_addr_i = '0; status_i = '0; cause_i = '0; epc_i = '0;
  endtask

  typedef struct packed {
    logic [8:0]  flags;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] addr;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] e_type;
    logic        e_ds;
    logic [31:0] e_bad;
    logic [31:0] e_newpc;
  } vec_t;

  localparam logic [31:0] VEC = 32'hBFC0_0380;
  vec_t vecs [12];

  initial begin
    //          flags   pc            ds    addr          status        cause         epc           type   ds    bad           newpc
    vecs[0]  = '{9'h010, 32'hBFC00100, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h08, 1'b0, 32'h0,        VEC};
    vecs[1]  = '{9'h006, 32'h80001000, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0a, 1'b1, 32'h0,        VEC};
    vecs[2]  = '{9'h100, 32'h80000400, 1'b0, 32'h0,        32'h0,        32'h0,        32'hBFC00200, 32'h0e, 1'b0, 32'h0,        32'hBFC00200};
    vecs[3]  = '{9'h004, 32'h80000500, 1'b0, 32'h0,        32'h0000FF01, 32'h00000400, 32'h0,        32'h01, 1'b0, 32'h0,        VEC};
    vecs[4]  = '{9'h004, 32'h80000504, 1'b0, 32'h0,        32'h0000FF03, 32'h00000400, 32'h0,        32'h0c, 1'b0, 32'h0,        VEC};
    vecs[5]  = '{9'h001, 32'h80000002, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h04, 1'b0, 32'h80000002, VEC};
    vecs[6]  = '{9'h040, 32'h80000020, 1'b0, 32'h80000011, 32'h0,        32'h0,        32'h0,        32'h04, 1'b0, 32'h80000011, VEC};
    vecs[7]  = '{9'h018, 32'h80000030, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0d, 1'b1, 32'h0,        VEC};
    vecs[8]  = '{9'h060, 32'h80000040, 1'b0, 32'h80000044, 32'h0,        32'h0,        32'h0,        32'h09, 1'b0, 32'h0,        VEC};
    vecs[9]  = '{9'h081, 32'h80000006, 1'b0, 32'h8000000c, 32'h0,        32'h0,        32'h0,        32'h04, 1'b0, 32'h80000006, VEC};
    vecs[10] = '{9'h010, 32'h80000060, 1'b0, 32'h0,        32'h0000FB01, 32'h00000400, 32'h0,        32'h08, 1'b0, 32'h0,        VEC};
    vecs[11] = '{9'h002, 32'h80000070, 1'b0, 32'h0,        32'h0000FF00, 32'h00000400, 32'h0,        32'h0a, 1'b0, 32'h0,        VEC};

    rst = 1'b0;
    int_i = '0;
    clear_inputs();
    step();
    step();
    chk_quiet("reset");
    chk("reset.int_sync", {26'h0, int_sync_o}, 32'h0);
    rst = 1'b1;
    step();
    chk_quiet("idle");

    for (int i = 0; i < 12; i++) begin
      valid_i = 1'b1; exc_flags_i = vecs[i].flags; pc_i = vecs[i].pc;
      is_in_delayslot_i = vecs[i].ds; mem_addr_i = vecs[i].addr;
      status_i = vecs[i].status; cause_i = vecs[i].cause; epc_i = vecs[i].epc;
      step();
      chk($sformatf("v%0d.type", i),  excepttype_o, vecs[i].e_type);
      chk($sformatf("v%0d.pc", i),    exc_pc_o, vecs[i].pc);
      chk($sformatf("v%0d.ds", i),    {31'h0, exc_delayslot_o}, {31'h0, vecs[i].e_ds});
      chk($sformatf("v%0d.bad", i),   bad_addr_o, vecs[i].e_bad);
      chk($sformatf("v%0d.newpc", i), newpc_o, vecs[i].e_newpc);
      chk($sformatf("v%0d.flush", i), {31'h0, flush_o}, 32'h1);
      clear_inputs();
      step();
      chk_quiet($sformatf("v%0d.after", i));
    end

    // ades held across a 3-cycle stall; inputs change under HOLD and must be ignored
    valid_i = 1'b1; exc_flags_i = 9'h080; pc_i = 32'h80000100; mem_addr_i = 32'h80000003; stall_i = 1'b1;
    step();
    chk_quiet("hold0");
    valid_i = 1'b1; exc_flags_i = 9'h010; mem_addr_i = 32'h12345678; pc_i = 32'h0;
    step();
    chk_quiet("hold1");
    step();
    chk_quiet("hold2");
    stall_i = 1'b0; valid_i = 1'b0; exc_flags_i = '0;
    step();
    chk("hold.type",  excepttype_o, 32'h05);
    chk("hold.bad",   bad_addr_o, 32'h80000003);
    chk("hold.pc",    exc_pc_o, 32'h80000100);
    chk("hold.flush", {31'h0, flush_o}, 32'h1);
    step();
    chk_quiet("hold.after");

    // interrupt pending on a bubble never commits
    status_i = 32'h0000FF01; cause_i = 32'h00000400; valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet($sformatf("bubble%0d", k));
    end
    clear_inputs();

    // int_i pulse appears on int_sync_o two edges later, for one cycle
    int_i = 6'h01;
    step();
    chk("sync.e1", {26'h0, int_sync_o}, 32'h0);
    int_i = 6'h00;
    step();
    chk("sync.e2", {26'h0, int_sync_o}, 32'h1);
    step();
    chk("sync.e3", {26'h0, int_sync_o}, 32'h0);

    // reset asserted while in HOLD aborts the exception
    valid_i = 1'b1; exc_flags_i = 9'h010; pc_i = 32'h80000200; stall_i = 1'b1;
    step();
    clear_inputs();
    rst = 1'b0;
    #1;
    chk_quiet("rst_hold");
    #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_quiet($sformatf("rst_hold.post%0d", k));
    end

    // reset asserted during COMMIT clears outputs at once
    valid_i = 1'b1; exc_flags_i = 9'h010; pc_i = 32'h80000300;
    step();
    chk("rst_commit.pre", excepttype_o, 32'h08);
    clear_inputs();
    rst = 1'b0;
    #1;
    chk_quiet("rst_commit");
    rst = 1'b1;
    step();
    chk_quiet("rst_commit.post");

    // sys still asserted during the COMMIT cycle is not detected
    valid_i = 1'b1; exc_flags_i = 9'h010; pc_i = 32'h80000400;
    step();
    chk("supp.commit", excepttype_o, 32'h08);
    step();
    chk_quiet("supp.next");
    clear_inputs();
    step();
    chk_quiet("supp.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
